// File: rtl/onewire_slot_receiver.sv
// onewire_slot_receiver: 1-Wire slave write-slot receiver.
// Decodes master write slots into bytes (LSB first) once the presence reply
// is done (en_rx), and flags reset-length bus lows back to the sequencer.
// Optional feature macro: ONEWIRE_RX_GLITCH_FILTER_EN (a slot starts only
// after two consecutive low samples; single-cycle lows are ignored).
// The block only observes the bus; it never drives it.
module onewire_slot_receiver #(
    parameter int SAMPLE_POINT = 30,
    parameter int RESET_MIN    = 480,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus,
    input  logic       en_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       reset_seen,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FALL = 2'd1,
        SAMPLE    = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);
    localparam logic [CNT_W-1:0] RESET_CNT  = CNT_W'(RESET_MIN);

    // Synchronizer and edge-history flops; all idle high.
    logic bus_meta_q;
    logic bus_s_q;
    logic bus_prev_q;
`ifdef ONEWIRE_RX_GLITCH_FILTER_EN
    logic bus_prev2_q;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             reset_seen_q, reset_seen_d;
    logic             busy_q, busy_d;

    logic             slot_start;
    logic [CNT_W-1:0] start_cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Two-flop synchronizer plus history of the synchronized level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_meta_q  <= 1'b1;
            bus_s_q     <= 1'b1;
            bus_prev_q  <= 1'b1;
`ifdef ONEWIRE_RX_GLITCH_FILTER_EN
            bus_prev2_q <= 1'b1;
`endif
        end else begin
            bus_meta_q  <= bus;
            bus_s_q     <= bus_meta_q;
            bus_prev_q  <= bus_s_q;
`ifdef ONEWIRE_RX_GLITCH_FILTER_EN
            bus_prev2_q <= bus_prev_q;
`endif
        end
    end

    // Slot start detection; the filtered variant starts one cycle later and
    // preloads the counter one higher so the sample point stays put.
    always_comb begin
`ifdef ONEWIRE_RX_GLITCH_FILTER_EN
        slot_start = bus_prev2_q & ~bus_prev_q & ~bus_s_q;
        start_cnt  = CNT_W'(2);
`else
        slot_start = bus_prev_q & ~bus_s_q;
        start_cnt  = CNT_W'(1);
`endif
        cnt_inc = (cnt_q == RESET_CNT) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state and datapath logic for the slot decoder.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = 1'b0;
        reset_seen_d = 1'b0;
        if (!en_rx) begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = WAIT_FALL;
                end
                WAIT_FALL: begin
                    if (slot_start) begin
                        cnt_d   = start_cnt;
                        state_d = SAMPLE;
                    end
                end
                SAMPLE: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == SAMPLE_CNT) begin
                        shift_d   = {bus_s_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d  = {bus_s_q, shift_q[7:1]};
                            rx_valid_d = 1'b1;
                        end
                        state_d = bus_s_q ? WAIT_FALL : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (cnt_q == RESET_CNT) begin
                        reset_seen_d = 1'b1;
                        bit_cnt_d    = '0;
                        shift_d      = '0;
                        state_d      = WAIT_FALL;
                    end else if (bus_s_q) begin
                        state_d = WAIT_FALL;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == SAMPLE) || (state_d == WAIT_HIGH);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            reset_seen_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            reset_seen_q <= reset_seen_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign reset_seen = reset_seen_q;
    assign busy       = busy_q;

endmodule

// File: doc/onewire_slot_receiver.md
# onewire_slot_receiver

1-Wire slave write-slot receiver: after the presence reply completes, it decodes master write time slots on the shared bus into bytes, LSB first, for the downstream ROM/function command decoder. It sits directly downstream of the presence replier: that block's `done_precence` drives `en_rx`. A bus-low of reset length aborts reception and is flagged back to the reset/presence sequencing logic.

## Interface
- `SAMPLE_POINT`, 30: clk cycles from the slot's falling edge to the bit sample (1 clk = 1 µs nominal).
- `RESET_MIN`, 480: continuous bus-low cycles, counted from the falling edge, that constitute a reset pulse.
- `CNT_W`, 10: slot counter width. Must hold `RESET_MIN`.

- `clk` input 1: system clock, 1 µs nominal period.
- `rst_n` input 1: synchronous, active-low reset.
- `bus` input 1: raw 1-Wire line level. It is asynchronous and goes through a 2-flop synchronizer inside the block.
- `en_rx` input 1: receive enable, held high for the whole receive phase.
- `rx_byte` output 8: last completed byte, LSB = first bit received.
- `rx_valid` output 1: one-cycle pulse when `rx_byte` updates.
- `reset_seen` output 1: one-cycle pulse when a reset-length low is detected.
- `busy` output 1: high while a slot is in progress (states SAMPLE and WAIT_HIGH).

## Operation
- The synchronized bus is called `bus_s`; it lags `bus` by 2 cycles. A falling edge means the previous cycle's `bus_s` was 1 and the current one is 0.
- States:
  - IDLE: entered from reset, or from any state when `en_rx` = 0. It clears `bit_cnt`, the shift register and the slot counter. Goes to WAIT_FALL when `en_rx` = 1.
  - WAIT_FALL: a falling edge loads `cnt` = 1 and goes to SAMPLE.
  - SAMPLE: `cnt` increments every cycle, independent of bus level.
    - When `cnt` = `SAMPLE_POINT`, `bus_s` is shifted into bit 7 of the shift register (right shift) and `bit_cnt` increments.
    - If `bus_s` is 1 at that point the state goes to WAIT_FALL, otherwise to WAIT_HIGH.
  - WAIT_HIGH: `cnt` keeps incrementing while `bus_s` = 0.
    - `bus_s` = 1 goes to WAIT_FALL.
    - `cnt` = `RESET_MIN` pulses `reset_seen`, clears `bit_cnt` and the shift register, and goes to WAIT_FALL.
- Byte completion: on the 8th sample, `rx_byte` is loaded with the complete shifted value and `rx_valid` pulses. `bit_cnt` wraps to 0 and reception continues into the next byte with no gap.
- `en_rx` falling mid-byte: go to IDLE and discard the partial byte. No `rx_valid`. `rx_byte` holds its previous value.
- A slot that is low past `SAMPLE_POINT` but shorter than `RESET_MIN` is a valid 0 bit.
- A reset during a byte discards that byte. A reset with `bit_cnt` = 0 still pulses `reset_seen`.
- Any falling edge seen during SAMPLE is ignored. Slots shorter than `SAMPLE_POINT` do not start a new bit.
- The block never drives the bus.

## Timing
- Reset values: `rx_byte` = 8'h00, `rx_valid` = 0, `reset_seen` = 0, `busy` = 0, state = IDLE, `cnt` = 0, `bit_cnt` = 0. Both synchronizer flops reset to 1 (idle-high bus).
- Bit sample time: `SAMPLE_POINT` + 2 cycles after the raw `bus` falling edge.
- `rx_valid` is registered. It is asserted in the cycle after the 8th sample and lasts exactly 1 cycle.
- `reset_seen` is asserted in the cycle after `cnt` reaches `RESET_MIN`, i.e. `RESET_MIN` + 3 cycles after the raw falling edge, and lasts 1 cycle.
- `rx_valid` and `reset_seen` are never asserted in the same cycle: a reset can only be reached in WAIT_HIGH, after the sample was taken.
- `cnt` saturates at `RESET_MIN`. There is no wrap-around.
- `busy` is registered and updates with the state.
- If `rst_n` and `en_rx` act in the same cycle, `rst_n` has priority.

## Configuration
- `ONEWIRE_RX_GLITCH_FILTER_EN` defined:
  - A falling edge starts a slot only if `bus_s` stays 0 for 2 consecutive cycles.
  - `cnt` is loaded with 2 on entry to SAMPLE, so the sample point is unchanged relative to the true edge.
  - A 1-cycle low pulse is ignored.
- Not defined: a single-cycle low on `bus_s` starts a slot.

## Test plan
- `en_rx` = 1, master writes 8'hCC as slots: 0-bit = 60 µs low, 1-bit = 6 µs low, 70 µs slot period. Expect a single `rx_valid` pulse with `rx_byte` = 8'hCC and `busy` low between slots.
- Two back-to-back bytes, 8'h33 then 8'hF0. Expect two `rx_valid` pulses, `rx_byte` = 8'h33 then 8'hF0, and no lost bit at the byte boundary.
- After 3 bits, hold the bus low for 500 µs. Expect `reset_seen` pulsed once at 483 cycles after the edge and no `rx_valid`. A following 8'hA5 is received correctly.
- Drop `en_rx` after 5 bits, then re-raise it and send 8'h0F. Expect exactly one `rx_valid` with `rx_byte` = 8'h0F.
- Inject a 1-cycle low glitch, then send 8'h55:
  - With `ONEWIRE_RX_GLITCH_FILTER_EN`: `rx_byte` = 8'h55.
  - Without it: the glitch is taken as bit0 = 1, giving a misaligned byte.
- Assert `rst_n` = 0 mid-slot. Expect all outputs at their reset values the next cycle and state IDLE.
